// File: rtl/frame_pkg.sv
// Types and constants shared by the frame scheduler and the frame generator.
package frame_pkg;

    localparam int FRAME_BYTES  = 16;
    localparam int FRAME_CYCLES = 17;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        START = 2'd2,
        SEND  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester found searching upward
// from the channel after the last one served.
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IW-1:0]     last_idx,
    output logic [NUM_CH-1:0] grant,
    output logic [IW-1:0]     idx
);

    int            cand_int_s;
    logic [IW-1:0] cand_s;
    logic          found_s;

    // Rotating priority search, wrapping modulo NUM_CH
    always_comb begin
        grant      = '0;
        idx        = '0;
        found_s    = 1'b0;
        cand_int_s = 0;
        cand_s     = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand_int_s = (int'(last_idx) + i) % NUM_CH;
            cand_s     = IW'(cand_int_s);
            if (!found_s && req[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                idx           = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/frame_tx_scheduler.sv
// Shares one frame generator among NUM_CH channels: round-robin grant,
// byte-wise load into a holding buffer, start pulse, then hold until sent.
module frame_tx_scheduler
    import frame_pkg::*;
#(
    parameter  int NUM_CH       = 4,
    parameter  int FRAME_BYTES  = frame_pkg::FRAME_BYTES,
    parameter  int FRAME_CYCLES = frame_pkg::FRAME_CYCLES,
    localparam int IW           = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        ch_req,
    output logic [NUM_CH-1:0]        ch_grant,
    input  logic                     ch_valid,
    input  logic [7:0]               ch_data,
    output logic                     ch_ready,
    output logic                     gen_start,
    output logic [8*FRAME_BYTES-1:0] gen_frame_data,
    output logic                     frame_done,
    output logic [IW-1:0]            frame_ch,
    output logic                     busy
);

    localparam int            CW       = $clog2(FRAME_BYTES);
    localparam int            TW       = $clog2(FRAME_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(FRAME_CYCLES - 1);
    localparam logic [TW-1:0] TMR_DONE = TW'(FRAME_CYCLES - 2);

    sched_state_t             state_r;
    sched_state_t             state_nxt_s;
    logic [CW-1:0]            cnt_r;
    logic [TW-1:0]            timer_r;
    logic [8*FRAME_BYTES-1:0] buf_r;
    logic [NUM_CH-1:0]        grant_r;
    logic [NUM_CH-1:0]        arb_grant_s;
    logic [IW-1:0]            frame_ch_r;
    logic [IW-1:0]            last_ch_r;
    logic [IW-1:0]            arb_idx_s;
    logic                     gen_start_r;
    logic                     frame_done_r;
    logic                     busy_r;
    logic                     accept_s;
    logic                     abort_s;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req      (ch_req),
        .last_idx (last_ch_r),
        .grant    (arb_grant_s),
        .idx      (arb_idx_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode; a dropped request in LOAD takes priority over a byte
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (|ch_req) state_nxt_s = LOAD;
                else         state_nxt_s = IDLE;
            end
            LOAD: begin
                if (!ch_req[frame_ch_r]) begin
                    abort_s     = 1'b1;
                    state_nxt_s = IDLE;
                end else if (ch_valid) begin
                    accept_s = 1'b1;
                    if (cnt_r == CNT_LAST) state_nxt_s = START;
                    else                   state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            START:   state_nxt_s = SEND;
            SEND: begin
                if (timer_r == TMR_LAST) state_nxt_s = IDLE;
                else                     state_nxt_s = SEND;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Grant, counters, buffer and registered strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_r      <= '0;
            frame_ch_r   <= '0;
            last_ch_r    <= IW'(NUM_CH - 1);
            cnt_r        <= '0;
            timer_r      <= '0;
            buf_r        <= '0;
            gen_start_r  <= 1'b0;
            frame_done_r <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            gen_start_r  <= (state_nxt_s == START);
            // Raised one cycle early so the pulse lands on the final SEND cycle
            frame_done_r <= (state_r == SEND) && (timer_r == TMR_DONE);
            busy_r       <= (state_nxt_s != IDLE);
            case (state_r)
                IDLE: begin
                    if (|ch_req) begin
                        grant_r    <= arb_grant_s;
                        frame_ch_r <= arb_idx_s;
                        cnt_r      <= '0;
                    end
                end
                LOAD: begin
                    if (abort_s) begin
                        grant_r   <= '0;
                        last_ch_r <= frame_ch_r;
                    end else if (accept_s) begin
                        buf_r[{cnt_r, 3'b000} +: 8] <= ch_data;
                        if (cnt_r != CNT_LAST) cnt_r <= cnt_r + CW'(1);
                    end
                end
                START: timer_r <= '0;
                SEND: begin
                    if (timer_r == TMR_LAST) begin
                        grant_r   <= '0;
                        last_ch_r <= frame_ch_r;
                    end else begin
                        timer_r <= timer_r + TW'(1);
                    end
                end
                default: grant_r <= '0;
            endcase
        end
    end

    assign ch_ready       = (state_r == LOAD);
    assign ch_grant       = grant_r;
    assign frame_ch       = frame_ch_r;
    assign gen_start      = gen_start_r;
    assign frame_done     = frame_done_r;
    assign busy           = busy_r;
    assign gen_frame_data = buf_r;

endmodule
